// File: rtl/hazard_scoreboard_pkg.sv
// Shared ID-stage definitions: register/pipe geometry, stage indices,
// scoreboard entry layout and the credit-counter width helper.
package hazard_scoreboard_pkg;

  localparam int REG_AW     = 5;
  localparam int PIPE_DEPTH = 3;

  localparam int IDX_EX  = 0;
  localparam int IDX_MEM = 1;
  localparam int IDX_SAD = 2;

  typedef struct packed {
    logic              v;
    logic [REG_AW-1:0] wreg;
  } sb_entry_t;

  // Bits needed to hold 0..max_credits inclusive.
  function automatic int credit_w(input int max_credits);
    return (max_credits < 1) ? 1 : $clog2(max_credits + 1);
  endfunction

endpackage

// File: rtl/hazard_scoreboard_if.sv
// ID-stage decoder <-> hazard scoreboard bundle. The decoder side (master)
// drives operand/destination info and consumes the stall and status.
interface hazard_scoreboard_if
  import hazard_scoreboard_pkg::*;
#(
  parameter int REG_AW = 5,
  parameter int CRED_W = 3,
  parameter int PERF_W = 16
);

  logic                   id_valid;
  logic [REG_AW-1:0]      id_rs;
  logic [REG_AW-1:0]      id_rt;
  logic                   id_rs_used;
  logic                   id_rt_used;
  logic                   id_regwrite;
  logic [REG_AW-1:0]      id_wreg;
  logic                   id_need_buf;
  logic                   id_flush;
  logic                   buf_fill_done;

  logic                   id_stall;
  logic [2**REG_AW-1:0]   pending_mask;
  logic [CRED_W-1:0]      credits;
  logic [PERF_W-1:0]      stall_cycles;
  logic                   err_overflow;

  modport master (
    output id_valid, id_rs, id_rt, id_rs_used, id_rt_used, id_regwrite,
           id_wreg, id_need_buf, id_flush, buf_fill_done,
    input  id_stall, pending_mask, credits, stall_cycles, err_overflow
  );

  modport slave (
    input  id_valid, id_rs, id_rt, id_rs_used, id_rt_used, id_regwrite,
           id_wreg, id_need_buf, id_flush, buf_fill_done,
    output id_stall, pending_mask, credits, stall_cycles, err_overflow
  );

endinterface

// File: rtl/hazard_scoreboard_buf_credit_counter.sv
// SAD buffer-load credit counter: one credit per LBUF issue, one back per
// fill pulse, saturating at BUF_CREDITS with a sticky overflow flag.
module buf_credit_counter
  import hazard_scoreboard_pkg::*;
#(
  parameter int BUF_CREDITS  = 4,
  parameter int INIT_CREDITS = 0
) (
  input  logic                             Clk,
  input  logic                             Reset_n,
  input  logic                             take_i,
  input  logic                             give_i,
  output logic [credit_w(BUF_CREDITS)-1:0] credits_o,
  output logic                             empty_o,
  output logic                             err_overflow_o
);

  localparam int                CRED_W    = credit_w(BUF_CREDITS);
  localparam logic [CRED_W-1:0] CRED_MAX  = CRED_W'(BUF_CREDITS);
  localparam logic [CRED_W-1:0] CRED_INIT = CRED_W'(INIT_CREDITS);

  logic [CRED_W-1:0] credits_q, credits_d;
  logic              err_q, err_d;

  // take is only ever asserted with credits > 0, so no underflow guard here.
  always_comb begin
    credits_d = credits_q;
    err_d     = err_q;
    case ({take_i, give_i})
      2'b10: credits_d = credits_q - 1'b1;
      2'b01: begin
        if (credits_q == CRED_MAX) err_d = 1'b1;
        else                       credits_d = credits_q + 1'b1;
      end
      default: ;
    endcase
  end

  always_ff @(posedge Clk or negedge Reset_n) begin
    if (!Reset_n) begin
      credits_q <= CRED_INIT;
      err_q     <= 1'b0;
    end else begin
      credits_q <= credits_d;
      err_q     <= err_d;
    end
  end

  assign credits_o      = credits_q;
  assign empty_o        = (credits_q == '0);
  assign err_overflow_o = err_q;

endmodule

// File: rtl/hazard_scoreboard.sv
// Decode-stage RAW hazard detection: shift scoreboard of in-flight
// destinations, optional forwarding cut-off and buffer-credit stall.
module hazard_scoreboard
  import hazard_scoreboard_pkg::*;
#(
  parameter int REG_AW       = hazard_scoreboard_pkg::REG_AW,
  parameter int PIPE_DEPTH   = hazard_scoreboard_pkg::PIPE_DEPTH,
  parameter int FWD_STAGE    = PIPE_DEPTH,
  parameter int BUF_CREDITS  = 4,
  parameter int INIT_CREDITS = 0,
  parameter int PERF_W       = 16
) (
  input  logic         Clk,
  input  logic         Reset_n,
  hazard_scoreboard_if.slave bus
);

  localparam int NREG   = 2**REG_AW;
  localparam int CRED_W = credit_w(BUF_CREDITS);

  sb_entry_t         sb_q [PIPE_DEPTH];
  sb_entry_t         sb_d [PIPE_DEPTH];
  logic [NREG-1:0]   mask_q, mask_d;
  logic [PERF_W-1:0] stall_q, stall_d;

  logic              haz_rs, haz_rt, buf_stall, stall;
  logic              issue, take, cred_empty, err_ovf;
  logic [CRED_W-1:0] credits;

  // Only entries below FWD_STAGE block; later ones are forwarded.
  always_comb begin
    haz_rs = 1'b0;
    haz_rt = 1'b0;
    for (int i = 0; i < FWD_STAGE; i++) begin
      if (sb_q[i].v && (sb_q[i].wreg == bus.id_rs)) haz_rs = 1'b1;
      if (sb_q[i].v && (sb_q[i].wreg == bus.id_rt)) haz_rt = 1'b1;
    end
    haz_rs = haz_rs & bus.id_rs_used & (bus.id_rs != '0);
    haz_rt = haz_rt & bus.id_rt_used & (bus.id_rt != '0);
  end

  assign buf_stall = bus.id_need_buf & cred_empty;
  assign stall     = Reset_n & bus.id_valid & ~bus.id_flush
                   & (haz_rs | haz_rt | buf_stall);
  assign issue     = bus.id_valid & ~stall & ~bus.id_flush
                   & bus.id_regwrite & (bus.id_wreg != '0);
  assign take      = bus.id_need_buf & bus.id_valid & ~stall & ~bus.id_flush;

  // Mask is built from next-state so it lines up with sb_q every cycle.
  always_comb begin
    sb_d[IDX_EX] = issue ? '{v: 1'b1, wreg: bus.id_wreg} : '0;
    for (int i = 1; i < PIPE_DEPTH; i++) sb_d[i] = sb_q[i-1];
    mask_d = '0;
    for (int i = 0; i < PIPE_DEPTH; i++) begin
      if (sb_d[i].v) mask_d[sb_d[i].wreg] = 1'b1;
    end
    mask_d[0] = 1'b0;
    stall_d = stall_q;
    if (stall && !(&stall_q)) stall_d = stall_q + 1'b1;
  end

  always_ff @(posedge Clk or negedge Reset_n) begin
    if (!Reset_n) begin
      for (int i = 0; i < PIPE_DEPTH; i++) sb_q[i] <= '0;
      mask_q  <= '0;
      stall_q <= '0;
    end else begin
      for (int i = 0; i < PIPE_DEPTH; i++) sb_q[i] <= sb_d[i];
      mask_q  <= mask_d;
      stall_q <= stall_d;
    end
  end

  buf_credit_counter #(
    .BUF_CREDITS  (BUF_CREDITS),
    .INIT_CREDITS (INIT_CREDITS)
  ) u_credits (
    .Clk            (Clk),
    .Reset_n        (Reset_n),
    .take_i         (take),
    .give_i         (bus.buf_fill_done),
    .credits_o      (credits),
    .empty_o        (cred_empty),
    .err_overflow_o (err_ovf)
  );

  assign bus.id_stall     = stall;
  assign bus.pending_mask = mask_q;
  assign bus.credits      = credits;
  assign bus.stall_cycles = stall_q;
  assign bus.err_overflow = err_ovf;

endmodule

// File: tb/tb_hazard_scoreboard.sv
// Bench for hazard_scoreboard: two instances (no forwarding / FWD_STAGE=1)
// on shared stimulus, checked each cycle against an issue-history model.
module tb_hazard_scoreboard;

  localparam int NC = 4096;

  logic Clk = 1'b0;
  logic Reset_n;
  always #5 Clk = ~Clk;

  logic       id_valid, id_rs_used, id_rt_used, id_regwrite;
  logic       id_need_buf, id_flush, buf_fill_done;
  logic [4:0] id_rs, id_rt, id_wreg;

  hazard_scoreboard_if #(.REG_AW(5), .CRED_W(3), .PERF_W(16)) ifa ();
  hazard_scoreboard_if #(.REG_AW(5), .CRED_W(3), .PERF_W(16)) ifb ();

  assign ifa.id_valid = id_valid;       assign ifb.id_valid = id_valid;
  assign ifa.id_rs = id_rs;             assign ifb.id_rs = id_rs;
  assign ifa.id_rt = id_rt;             assign ifb.id_rt = id_rt;
  assign ifa.id_rs_used = id_rs_used;   assign ifb.id_rs_used = id_rs_used;
  assign ifa.id_rt_used = id_rt_used;   assign ifb.id_rt_used = id_rt_used;
  assign ifa.id_regwrite = id_regwrite; assign ifb.id_regwrite = id_regwrite;
  assign ifa.id_wreg = id_wreg;         assign ifb.id_wreg = id_wreg;
  assign ifa.id_need_buf = id_need_buf; assign ifb.id_need_buf = id_need_buf;
  assign ifa.id_flush = id_flush;       assign ifb.id_flush = id_flush;
  assign ifa.buf_fill_done = buf_fill_done;
  assign ifb.buf_fill_done = buf_fill_done;

  hazard_scoreboard #(.FWD_STAGE(3), .BUF_CREDITS(4), .INIT_CREDITS(0)) dut_a (
    .Clk(Clk), .Reset_n(Reset_n), .bus(ifa.slave));
  hazard_scoreboard #(.FWD_STAGE(1), .BUF_CREDITS(4), .INIT_CREDITS(2)) dut_b (
    .Clk(Clk), .Reset_n(Reset_n), .bus(ifb.slave));

  int errors = 0;
  int checks = 0;

  task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %0h expected %0h (t=%0t)", name, act, exp, $time);
    end
  endtask

  // Model: per instance, which register (0 = none) was issued in each cycle.
  int fwd  [2] = '{3, 1};
  int init [2] = '{0, 2};
  int iss  [2][NC];
  int cred [2];
  int scnt [2];
  bit err  [2];
  int cyc = 0;

  function automatic bit written_within(input int d, input int r, input int lim);
    if (r == 0) return 1'b0;
    for (int k = 1; k <= lim; k++)
      if (cyc - k >= 0 && iss[d][cyc-k] == r) return 1'b1;
    return 1'b0;
  endfunction

  initial begin
    for (int d = 0; d < 2; d++) begin
      for (int t = 0; t < NC; t++) iss[d][t] = 0;
      cred[d] = init[d]; scnt[d] = 0; err[d] = 1'b0;
    end
    forever begin
      @(negedge Clk);
      for (int d = 0; d < 2; d++) begin
        bit s, tk;
        logic [31:0] m;
        if (!Reset_n) begin
          for (int k = 0; k <= 3; k++) if (cyc - k >= 0) iss[d][cyc-k] = 0;
          cred[d] = init[d]; scnt[d] = 0; err[d] = 1'b0;
          s = 1'b0;
        end else begin
          s = id_valid && !id_flush &&
              ((id_rs_used && written_within(d, id_rs, fwd[d])) ||
               (id_rt_used && written_within(d, id_rt, fwd[d])) ||
               (id_need_buf && cred[d] == 0));
        end
        m = '0;
        for (int r = 1; r < 32; r++) m[r] = written_within(d, r, 3);
        chk(d ? "b.id_stall" : "a.id_stall", d ? ifb.id_stall : ifa.id_stall, 64'(s));
        chk(d ? "b.pending_mask" : "a.pending_mask",
            d ? ifb.pending_mask : ifa.pending_mask, 64'(m));
        chk(d ? "b.credits" : "a.credits", d ? ifb.credits : ifa.credits, 64'(cred[d]));
        chk(d ? "b.stall_cycles" : "a.stall_cycles",
            d ? ifb.stall_cycles : ifa.stall_cycles, 64'(scnt[d]));
        chk(d ? "b.err_overflow" : "a.err_overflow",
            d ? ifb.err_overflow : ifa.err_overflow, 64'(err[d]));
        if (Reset_n) begin
          iss[d][cyc] = (id_valid && !s && !id_flush && id_regwrite) ? int'(id_wreg) : 0;
          tk = id_need_buf && id_valid && !s && !id_flush;
          if (tk && !buf_fill_done) cred[d]--;
          else if (!tk && buf_fill_done) begin
            if (cred[d] == 4) err[d] = 1'b1;
            else cred[d]++;
          end
          if (s && scnt[d] != 65535) scnt[d]++;
        end
      end
      if (cyc < NC - 1) cyc++;
    end
  end

  task automatic to_mid();  @(negedge Clk); #1; endtask
  task automatic to_next(); @(posedge Clk); #1; endtask

  task automatic idle();
    id_valid = 0; id_rs_used = 0; id_rt_used = 0; id_regwrite = 0;
    id_need_buf = 0; id_flush = 0; buf_fill_done = 0;
    id_rs = 0; id_rt = 0; id_wreg = 0;
  endtask

  task automatic instr(input logic [4:0] rs, input bit rsu, input logic [4:0] rt,
                       input bit rtu, input bit rw, input logic [4:0] wr);
    idle();
    id_valid = 1; id_rs = rs; id_rs_used = rsu; id_rt = rt; id_rt_used = rtu;
    id_regwrite = rw; id_wreg = wr;
  endtask

  task automatic idle_cycles(input int n);
    idle();
    for (int i = 0; i < n; i++) to_next();
  endtask

  initial begin
    logic [3:0] ea_stall, eb_stall, eb_p3;
    logic [2:0] ea_cred6 [6];
    logic [5:0] ea_err6;
    logic [2:0] ea_cred4 [4];

    idle();
    Reset_n = 0;
    to_mid();
    chk("reset a.pending_mask", ifa.pending_mask, 0);
    chk("reset a.credits", ifa.credits, 0);
    chk("reset b.credits", ifb.credits, 2);
    chk("reset a.stall_cycles", ifa.stall_cycles, 0);
    to_next(); to_next();
    Reset_n = 1;

    // ADD $3 then SUB reading $3 held four cycles
    instr(5'd1, 1, 5'd2, 1, 1, 5'd3);
    to_next();
    ea_stall = 4'b0111; eb_stall = 4'b0001; eb_p3 = 4'b0111;
    for (int i = 0; i < 4; i++) begin
      instr(5'd3, 1, 5'd0, 1, 1, 5'd4);
      to_mid();
      chk("raw a.id_stall", ifa.id_stall, ea_stall[i]);
      chk("raw b.id_stall", ifb.id_stall, eb_stall[i]);
      chk("raw b.pending3", ifb.pending_mask[3], eb_p3[i]);
      to_next();
    end
    idle();
    to_mid();
    chk("raw a.stall_cycles", ifa.stall_cycles, 3);
    chk("raw b.stall_cycles", ifb.stall_cycles, 1);
    to_next();
    idle_cycles(4);

    // LBUF with no credits waits for a fill
    instr(0, 0, 0, 0, 0, 0); id_need_buf = 1;
    to_mid(); chk("lbuf wait a.id_stall", ifa.id_stall, 1); to_next();
    instr(0, 0, 0, 0, 0, 0); id_need_buf = 1; buf_fill_done = 1;
    to_mid(); chk("lbuf fill a.id_stall", ifa.id_stall, 1); to_next();
    instr(0, 0, 0, 0, 0, 0); id_need_buf = 1;
    to_mid();
    chk("lbuf go a.id_stall", ifa.id_stall, 0);
    chk("lbuf go a.credits", ifa.credits, 1);
    to_next();
    idle();
    to_mid();
    chk("lbuf done a.credits", ifa.credits, 0);
    chk("lbuf done b.credits", ifb.credits, 0);
    to_next();

    // Five fills from zero: saturate at 4, fifth sets overflow
    ea_cred6 = '{3'd0, 3'd1, 3'd2, 3'd3, 3'd4, 3'd4};
    ea_err6  = 6'b100000;
    for (int i = 0; i < 6; i++) begin
      idle(); buf_fill_done = (i < 5);
      to_mid();
      chk("fill a.credits", ifa.credits, ea_cred6[i]);
      chk("fill a.err_overflow", ifa.err_overflow, ea_err6[i]);
      to_next();
    end

    // Two takes, then take+give at 2
    ea_cred4 = '{3'd4, 3'd3, 3'd2, 3'd2};
    for (int i = 0; i < 4; i++) begin
      if (i < 3) begin instr(0, 0, 0, 0, 0, 0); id_need_buf = 1; end
      else idle();
      buf_fill_done = (i == 2);
      to_mid();
      chk("takegive a.credits", ifa.credits, ea_cred4[i]);
      to_next();
    end

    Reset_n = 0; idle();
    to_mid();
    chk("rst a.err_overflow", ifa.err_overflow, 0);
    chk("rst a.credits", ifa.credits, 0);
    to_next();
    Reset_n = 1;

    // Register zero and JAL with unused sources
    instr(5'd0, 1, 5'd0, 1, 1, 5'd0); to_next();
    instr(5'd0, 1, 5'd0, 1, 0, 5'd0);
    to_mid();
    chk("zero a.id_stall", ifa.id_stall, 0);
    chk("zero a.pending_mask", ifa.pending_mask, 0);
    to_next();
    instr(5'd1, 1, 5'd2, 1, 1, 5'd5); to_next();
    instr(5'd5, 0, 5'd5, 0, 1, 5'd31);
    to_mid(); chk("jal a.id_stall", ifa.id_stall, 0); to_next();
    idle_cycles(4);

    // Flush wins over a hazard and loads nothing
    instr(5'd1, 0, 5'd2, 0, 1, 5'd6); to_next();
    instr(5'd6, 1, 5'd0, 0, 1, 5'd7); id_flush = 1;
    to_mid(); chk("flush a.id_stall", ifa.id_stall, 0); to_next();
    idle();
    to_mid();
    chk("flush a.pending6", ifa.pending_mask[6], 1);
    chk("flush a.pending7", ifa.pending_mask[7], 0);
    to_next();
    idle_cycles(3);

    // Reset dropped while stalled
    instr(5'd1, 0, 5'd2, 0, 1, 5'd8); to_next();
    instr(5'd8, 1, 5'd0, 0, 0, 5'd0);
    to_mid(); chk("pre-rst a.id_stall", ifa.id_stall, 1); to_next();
    #1 Reset_n = 0;
    #1;
    chk("midrst a.id_stall", ifa.id_stall, 0);
    chk("midrst a.pending_mask", ifa.pending_mask, 0);
    chk("midrst a.credits", ifa.credits, 0);
    chk("midrst b.credits", ifb.credits, 2);
    to_mid(); to_next();
    Reset_n = 1;
    idle_cycles(2);

    // Randomized traffic over a small register range for dense hazards
    for (int n = 0; n < 2500; n++) begin
      id_valid      = ($urandom_range(0, 9) < 8);
      id_rs         = 5'($urandom_range(0, 7));
      id_rt         = 5'($urandom_range(0, 7));
      id_rs_used    = ($urandom_range(0, 9) < 7);
      id_rt_used    = ($urandom_range(0, 9) < 5);
      id_regwrite   = ($urandom_range(0, 9) < 7);
      id_wreg       = 5'($urandom_range(0, 7));
      id_need_buf   = ($urandom_range(0, 99) < 15);
      buf_fill_done = ($urandom_range(0, 99) < 15);
      id_flush      = ($urandom_range(0, 9) == 0);
      Reset_n       = ($urandom_range(0, 299) != 0);
      to_next();
    end
    Reset_n = 1;
    idle_cycles(3);

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
